bcd_seg_scan: RTL and testbench

BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

---
 rtl/bcd_seg_scan.sv | 123 ++++++++++++
 tb/tb_bcd_seg_scan.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: 3-digit multiplexed 7-segment driver for a BCD sum + carry.
// Optional leading-zero blanking with `define BCD_SEG_SCAN_LZB_EN.
module bcd_seg_scan #(
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] bcd_in,
   input  logic       carry_in,
   output logic [6:0] seg_n,
   output logic [2:0] an_n,
   output logic       err,
   output logic       frame
);

   localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
   localparam logic [6:0] SEG_OFF  = 7'h7F;
   localparam logic [6:0] SEG_DASH = 7'h3F;

   logic [8:0]    val, val_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [1:0]    idx, idx_nxt;
   logic          wrap;
   logic          hund_blank, tens_blank;

   logic [6:0]    seg_q, seg_d;
   logic [2:0]    an_q, an_d;
   logic          err_q, err_d;
   logic          frame_q, frame_d;

   function automatic logic [6:0] dec7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

   // Next state of value/prescaler/index; outputs are precomputed from the
   // next state so the registered pins match the state of the same cycle.
   always_comb begin
      val_nxt = load ? {carry_in, bcd_in} : val;
      wrap    = (cnt == CNT_MAX);
      cnt_nxt = wrap ? '0 : cnt + 1'b1;
      idx_nxt = idx;
      if (wrap) begin
         idx_nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end

`ifdef BCD_SEG_SCAN_LZB_EN
      hund_blank = ~val_nxt[8];
      tens_blank = ~val_nxt[8] && (val_nxt[7:4] == 4'd0);
`else
      hund_blank = 1'b0;
      tens_blank = 1'b0;
`endif

      seg_d = SEG_OFF;
      an_d  = 3'b111;
      if (cnt_nxt != '0) begin
         case (idx_nxt)
            2'd0: begin
               an_d  = 3'b110;
               seg_d = dec7(val_nxt[3:0]);
            end
            2'd1: begin
               an_d  = 3'b101;
               seg_d = tens_blank ? SEG_OFF : dec7(val_nxt[7:4]);
            end
            2'd2: begin
               an_d  = 3'b011;
               seg_d = hund_blank ? SEG_OFF : dec7({3'b000, val_nxt[8]});
            end
            default: begin
               an_d  = 3'b111;
               seg_d = SEG_OFF;
            end
         endcase
      end

      err_d   = (val_nxt[7:4] > 4'd9) || (val_nxt[3:0] > 4'd9);
      frame_d = wrap && (idx == 2'd2);
   end

   // Scan state and glitch-free registered pin drivers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val     <= '0;
         cnt     <= '0;
         idx     <= '0;
         seg_q   <= SEG_OFF;
         an_q    <= 3'b111;
         err_q   <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         val     <= val_nxt;
         cnt     <= cnt_nxt;
         idx     <= idx_nxt;
         seg_q   <= seg_d;
         an_q    <= an_d;
         err_q   <= err_d;
         frame_q <= frame_d;
      end
   end

   assign seg_n = seg_q;
   assign an_n  = an_q;
   assign err   = err_q;
   assign frame = frame_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb_bcd_seg_scan: directed checks of bcd_seg_scan with SCAN_DIV=4.
// Step k = rising edges since reset release; slot = (k/4)%3, cnt = k%4.
module tb_bcd_seg_scan;

   logic       clk;
   logic       rst_n;
   logic       load;
   logic [7:0] bcd_in;
   logic       carry_in;
   logic [6:0] seg_n;
   logic [2:0] an_n;
   logic       err;
   logic       frame;

   int passes = 0;
   int fails  = 0;
   int total  = 0;
   int k      = 0;

`ifdef BCD_SEG_SCAN_LZB_EN
   localparam logic [6:0] HZ = 7'h7F;
   localparam logic [6:0] TZ = 7'h7F;
`else
   localparam logic [6:0] HZ = 7'h40;
   localparam logic [6:0] TZ = 7'h40;
`endif

   bcd_seg_scan #(.SCAN_DIV(4)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .load(load),
      .bcd_in(bcd_in),
      .carry_in(carry_in),
      .seg_n(seg_n),
      .an_n(an_n),
      .err(err),
      .frame(frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [8:0] obs,
                      input logic [8:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s k=%0d got=%h want=%h", tag, k, obs, exp);
      end
   endtask

   task automatic go(input int target);
      while (k < target) begin
         @(posedge clk);
         k++;
      end
      #1;
   endtask

   task automatic view(input string tag, input logic [2:0] a,
                       input logic [6:0] s);
      chk({tag, ".an"}, {6'd0, an_n}, {6'd0, a});
      chk({tag, ".seg"}, {2'd0, seg_n}, {2'd0, s});
   endtask

   initial begin
      rst_n    = 1'b0;
      load     = 1'b0;
      bcd_in   = 8'h00;
      carry_in = 1'b0;
      repeat (3) @(posedge clk);
      load = 1'b1;
      bcd_in = 8'h99;
      @(posedge clk);
      #1;
      load = 1'b0;
      chk("rst.seg", {2'd0, seg_n}, 9'h07F);
      chk("rst.an", {6'd0, an_n}, 9'h007);
      chk("rst.err", {8'd0, err}, 9'h000);
      chk("rst.frame", {8'd0, frame}, 9'h000);

      rst_n = 1'b1;
      k = 0;
      go(1);
      view("idle.c1", 3'b110, 7'h40);
      chk("idle.err", {8'd0, err}, 9'h000);
      chk("idle.frame0", {8'd0, frame}, 9'h000);
      go(3);
      view("idle.c3", 3'b110, 7'h40);
      go(4);
      view("idle.blank", 3'b111, 7'h7F);
      chk("first.noframe", {8'd0, frame}, 9'h000);
      go(5);
      view("idle.tens", 3'b101, TZ);
      go(9);
      view("idle.hund", 3'b011, HZ);
      go(12);
      chk("frame.k12", {8'd0, frame}, 9'h001);
      view("frame.blank", 3'b111, 7'h7F);
      go(13);
      chk("frame.k13", {8'd0, frame}, 9'h000);

      load = 1'b1; bcd_in = 8'h59; carry_in = 1'b1;
      go(14);
      load = 1'b0;
      view("59.ones", 3'b110, 7'h10);
      chk("59.err", {8'd0, err}, 9'h000);
      go(17);
      view("59.tens", 3'b101, 7'h12);
      go(21);
      view("59.hund", 3'b011, 7'h79);
      go(24);
      chk("frame.k24", {8'd0, frame}, 9'h001);
      go(35);
      chk("frame.k35", {8'd0, frame}, 9'h000);
      go(36);
      chk("frame.k36", {8'd0, frame}, 9'h001);

      load = 1'b1; bcd_in = 8'hA3; carry_in = 1'b0;
      go(37);
      load = 1'b0;
      chk("A3.err", {8'd0, err}, 9'h001);
      view("A3.ones", 3'b110, 7'h30);
      go(41);
      view("A3.tens", 3'b101, 7'h3F);
      go(45);
      view("A3.hund", 3'b011, HZ);

      load = 1'b1; bcd_in = 8'h07; carry_in = 1'b0;
      go(46);
      load = 1'b0;
      view("07.hund", 3'b011, HZ);
      chk("07.err", {8'd0, err}, 9'h000);
      go(49);
      view("07.ones", 3'b110, 7'h78);
      go(53);
      view("07.tens", 3'b101, TZ);

      go(55);
      load = 1'b1; bcd_in = 8'h42; carry_in = 1'b1;
      go(56);
      load = 1'b0;
      view("wrap.blank", 3'b111, 7'h7F);
      go(57);
      view("wrap.hund", 3'b011, 7'h79);
      go(60);
      chk("wrap.frame", {8'd0, frame}, 9'h001);
      go(61);
      view("42.ones", 3'b110, 7'h24);

      load = 1'b1; bcd_in = 8'h15; carry_in = 1'b0;
      go(62);
      chk("re1.err", {8'd0, err}, 9'h000);
      view("re1.ones", 3'b110, 7'h12);
      bcd_in = 8'hA3;
      go(63);
      load = 1'b0;
      chk("re2.err", {8'd0, err}, 9'h001);
      view("re2.ones", 3'b110, 7'h30);

      go(66);
      view("pre.tens", 3'b101, 7'h3F);
      #2;
      rst_n = 1'b0;
      #1;
      view("arst", 3'b111, 7'h7F);
      chk("arst.err", {8'd0, err}, 9'h000);
      @(posedge clk);
      #1;
      view("arst.hold", 3'b111, 7'h7F);
      rst_n = 1'b1;
      k = 0;
      go(1);
      view("rel.ones", 3'b110, 7'h40);
      chk("rel.frame", {8'd0, frame}, 9'h000);
      go(5);
      view("rel.tens", 3'b101, TZ);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
